apb_req_arbiter: RTL and testbench

//  APB master front-end that shares one APB bus between N_REQ local requesters.

---
 rtl/apb_req_arbiter.sv | 175 +++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin APB master front-end sharing one APB bus between N_REQ requesters.
// Ports:
//   pclk, preset        clock (rising edge), asynchronous active-high reset
//   req_i, write_i      per-requester level request and direction (1 = write)
//   addr_i, wdata_i     per-requester address / write data, slice [k*W +: W]
//   done_o, err_o       one-cycle completion pulse to the served requester, error flag
//   rdata_o             read data, valid with done_o on reads
//   psel_o .. pwdata_o  registered APB master outputs
//   pready_i, prdata_i  APB slave response
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_req_arbiter #(
    parameter int N_REQ          = 4,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ-1:0]    write_i,
    input  logic [N_REQ*AW-1:0] addr_i,
    input  logic [N_REQ*DW-1:0] wdata_i,
    output logic [N_REQ-1:0]    done_o,
    output logic                err_o,
    output logic [DW-1:0]       rdata_o,
    output logic                psel_o,
    output logic                penable_o,
    output logic                pwrite_o,
    output logic [AW-1:0]       paddr_o,
    output logic [DW-1:0]       pwdata_o,
    input  logic                pready_i,
    input  logic [DW-1:0]       prdata_i
);
    localparam int PW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            r_state, w_state_nx;
    logic [PW-1:0]     r_ptr, w_ptr_nx, r_gnt, w_gnt_nx, w_sel, w_idx, w_gnt_inc;
    logic [PW:0]       w_sum;
    logic [N_REQ-1:0]  w_elig, r_done, w_done_nx;
    logic              w_hit, w_tmo;
    logic              r_psel, w_psel_nx, r_penable, w_penable_nx, r_pwrite, w_pwrite_nx;
    logic [AW-1:0]     r_paddr, w_paddr_nx;
    logic [DW-1:0]     r_pwdata, w_pwdata_nx, r_rdata, w_rdata_nx;

    // Round-robin pick: scan offsets from high to low so the lowest offset from r_ptr wins.
    // The requester pulsed done this cycle is masked so it cannot be re-granted immediately.
    always_comb begin
        w_elig = req_i & ~r_done;
        w_hit  = 1'b0;
        w_sel  = r_ptr;
        w_sum  = '0;
        w_idx  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(i);
            w_idx = (w_sum >= (PW+1)'(N_REQ)) ? PW'(w_sum - (PW+1)'(N_REQ)) : w_sum[PW-1:0];
            if (w_elig[w_idx]) begin
                w_hit = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    assign w_gnt_inc = (r_gnt == PW'(N_REQ - 1)) ? '0 : r_gnt + 1'b1;

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_wait, w_wait_nx;
    logic          r_err;

    // r_wait holds the number of wait edges already taken; the next one is the last allowed.
    assign w_tmo = ~pready_i && (r_wait == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_wait_nx = r_wait;
        if (r_state == SETUP)
            w_wait_nx = '0;
        else if (r_state == ACCESS && !pready_i)
            w_wait_nx = r_wait + 1'b1;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wait <= w_wait_nx;
            r_err  <= (r_state == ACCESS) && w_tmo;
        end
    end

    assign err_o = r_err;
`else
    assign w_tmo = 1'b0;
    assign err_o = 1'b0;
`endif

    always_comb begin
        w_state_nx   = r_state;
        w_ptr_nx     = r_ptr;
        w_gnt_nx     = r_gnt;
        w_psel_nx    = r_psel;
        w_penable_nx = r_penable;
        w_pwrite_nx  = r_pwrite;
        w_paddr_nx   = r_paddr;
        w_pwdata_nx  = r_pwdata;
        w_rdata_nx   = r_rdata;
        w_done_nx    = '0;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_state_nx  = SETUP;
                    w_gnt_nx    = w_sel;
                    w_psel_nx   = 1'b1;
                    w_pwrite_nx = write_i[w_sel];
                    w_paddr_nx  = addr_i[w_sel*AW +: AW];
                    w_pwdata_nx = wdata_i[w_sel*DW +: DW];
                end
            end
            SETUP: begin
                w_state_nx   = ACCESS;
                w_penable_nx = 1'b1;
            end
            ACCESS: begin
                if (pready_i || w_tmo) begin
                    w_state_nx       = IDLE;
                    w_psel_nx        = 1'b0;
                    w_penable_nx     = 1'b0;
                    w_done_nx[r_gnt] = 1'b1;
                    w_ptr_nx         = w_gnt_inc;
                    // An aborted transfer never samples prdata.
                    if (pready_i && !r_pwrite)
                        w_rdata_nx = prdata_i;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_rdata   <= '0;
            r_done    <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_ptr     <= w_ptr_nx;
            r_gnt     <= w_gnt_nx;
            r_psel    <= w_psel_nx;
            r_penable <= w_penable_nx;
            r_pwrite  <= w_pwrite_nx;
            r_paddr   <= w_paddr_nx;
            r_pwdata  <= w_pwdata_nx;
            r_rdata   <= w_rdata_nx;
            r_done    <= w_done_nx;
        end
    end

    assign done_o    = r_done;
    assign rdata_o   = r_rdata;
    assign psel_o    = r_psel;
    assign penable_o = r_penable;
    assign pwrite_o  = r_pwrite;
    assign paddr_o   = r_paddr;
    assign pwdata_o  = r_pwdata;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed bench with a transfer-level reference model checked every cycle.
module tb_apb_req_arbiter;
    localparam int N = 4, AW = 32, DW = 32, TMO = 16;

    logic            pclk = 1'b0, preset = 1'b1;
    logic [N-1:0]    req = '0, wr = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic            pready = 1'b1;
    logic [DW-1:0]   prdata = '0;
    logic [N-1:0]    done_o;
    logic            err_o, psel_o, penable_o, pwrite_o;
    logic [DW-1:0]   rdata_o, pwdata_o;
    logic [AW-1:0]   paddr_o;

    apb_req_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .pclk(pclk), .preset(preset), .req_i(req), .write_i(wr), .addr_i(addr),
        .wdata_i(wdata), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
        .pwdata_o(pwdata_o), .pready_i(pready), .prdata_i(prdata)
    );

    always #5 pclk = ~pclk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: bus phase tracked as "idle / setup / access" booleans,
    // grant chosen by a plain modular scan from the pointer.
    int            m_ptr, m_g, m_wait;
    bit            m_psel, m_pen, m_pwrite, m_err;
    logic [AW-1:0] m_paddr;
    logic [DW-1:0] m_pwdata, m_rdata;
    logic [N-1:0]  m_done;
    int            q_grant[$];

    task automatic m_reset();
        m_ptr = 0; m_g = 0; m_wait = 0;
        m_psel = 0; m_pen = 0; m_pwrite = 0; m_err = 0;
        m_paddr = '0; m_pwdata = '0; m_rdata = '0; m_done = '0;
    endtask

    initial m_reset();

    always @(posedge pclk) begin
        logic [N-1:0] elig;
        bit tmo;
        if (preset) m_reset();
        else begin
            elig = req & ~m_done;
            m_done = '0;
            m_err = 0;
            if (!m_psel) begin
                for (int i = 0; i < N; i++)
                    if (!m_psel && elig[(m_ptr + i) % N]) begin
                        m_g = (m_ptr + i) % N;
                        m_psel = 1;
                        m_pwrite = wr[m_g];
                        m_paddr = addr[m_g*AW +: AW];
                        m_pwdata = wdata[m_g*DW +: DW];
                        q_grant.push_back(m_g);
                    end
            end else if (!m_pen) begin
                m_pen = 1;
                m_wait = 0;
            end else begin
                tmo = 0;
`ifdef APB_TIMEOUT_EN
                if (!pready) begin
                    m_wait++;
                    tmo = (m_wait == TMO);
                end
`endif
                if (pready || tmo) begin
                    m_psel = 0;
                    m_pen = 0;
                    m_done[m_g] = 1'b1;
                    m_err = tmo;
                    if (pready && !m_pwrite) m_rdata = prdata;
                    m_ptr = (m_g + 1) % N;
                end
            end
        end
        #1;
        if (!preset) begin
            chk("cyc_psel", psel_o, m_psel);
            chk("cyc_penable", penable_o, m_pen);
            chk("cyc_pwrite", pwrite_o, m_pwrite);
            chk("cyc_paddr", paddr_o, m_paddr);
            chk("cyc_pwdata", pwdata_o, m_pwdata);
            chk("cyc_done", done_o, m_done);
            chk("cyc_err", err_o, m_err);
            chk("cyc_rdata", rdata_o, m_rdata);
        end
        // Requesters drop their request during their done cycle.
        req = req & ~m_done;
    end

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (req != '0 && n < budget) begin
            @(negedge pclk);
            n++;
        end
        chk(nm, req, '0);
    endtask

    task automatic wait_access(input string nm);
        int n = 0;
        while (!penable_o && n < 10) begin
            @(negedge pclk);
            n++;
        end
        chk(nm, penable_o, 1'b1);
    endtask

    initial begin
        repeat (2) @(negedge pclk);
        chk("rst_psel", psel_o, 0);
        chk("rst_penable", penable_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_paddr", paddr_o, 0);
        preset = 1'b0;
        // 1: single write, zero wait states
        wr[0] = 1'b1; addr[0 +: AW] = 32'h10; wdata[0 +: DW] = 32'h1234ABCD; req = 4'b0001;
        @(posedge pclk); #2;
        chk("t1_psel", psel_o, 1);
        chk("t1_penable_setup", penable_o, 0);
        chk("t1_pwrite", pwrite_o, 1);
        chk("t1_paddr", paddr_o, 32'h10);
        chk("t1_pwdata", pwdata_o, 32'h1234ABCD);
        @(posedge pclk); #2;
        chk("t1_penable_access", penable_o, 1);
        @(posedge pclk); #2;
        chk("t1_done", done_o, 4'b0001);
        chk("t1_err", err_o, 0);
        chk("t1_psel_drop", psel_o, 0);
        @(posedge pclk); #2;
        chk("t1_done_pulse", done_o, 4'b0000);
        // 2: read returns data, a following write leaves it alone
        @(negedge pclk);
        wr[1] = 1'b0; addr[AW +: AW] = 32'h10; prdata = 32'h1234ABCD; req = 4'b0010;
        wait_idle("t2_rd_done", 20);
        chk("t2_rdata", rdata_o, 32'h1234ABCD);
        @(negedge pclk);
        wr[2] = 1'b1; addr[2*AW +: AW] = 32'h24; wdata[2*DW +: DW] = 32'h55; prdata = 32'hDEADBEEF;
        req = 4'b0100;
        wait_idle("t2_wr_done", 20);
        chk("t2_rdata_kept", rdata_o, 32'h1234ABCD);
        // 3: bring ptr to 0, then all four requesters together
        @(negedge pclk);
        wr[3] = 1'b0; addr[3*AW +: AW] = 32'h30; req = 4'b1000;
        wait_idle("t3_pre", 20);
        @(negedge pclk);
        q_grant.delete();
        wr = 4'b0000; req = 4'b1111;
        wait_idle("t3_all_done", 40);
        chk("t3_count", q_grant.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < q_grant.size()) chk($sformatf("t3_order%0d", i), q_grant[i], i);
        @(negedge pclk);
        req = 4'b0001;
        wait_idle("t3_ptr1", 20);
        @(negedge pclk);
        q_grant.delete();
        req = 4'b1001;
        wait_idle("t3_wrap_done", 30);
        chk("t3_wrap_count", q_grant.size(), 2);
        if (q_grant.size() == 2) begin
            chk("t3_wrap_first", q_grant[0], 3);
            chk("t3_wrap_second", q_grant[1], 0);
        end
        // 4: three wait states
        @(negedge pclk);
        pready = 1'b0; wr[2] = 1'b1; addr[2*AW +: AW] = 32'h20; wdata[2*DW +: DW] = 32'hA5A50F0F;
        req = 4'b0100;
        wait_access("t4_access");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_psel%0d", i), psel_o, 1);
            chk($sformatf("t4_penable%0d", i), penable_o, 1);
            chk($sformatf("t4_paddr%0d", i), paddr_o, 32'h20);
            chk($sformatf("t4_pwdata%0d", i), pwdata_o, 32'hA5A50F0F);
            chk($sformatf("t4_nodone%0d", i), done_o, 0);
            if (i == 3) pready = 1'b1;
            else @(negedge pclk);
        end
        @(posedge pclk); #2;
        chk("t4_done", done_o, 4'b0100);
        // 5: reset mid-ACCESS of requester 3; ptr returns to 0 so requester 1 goes first
        @(negedge pclk);
        prdata = 32'h0BADCAFE; wr[1] = 1'b0; wr[3] = 1'b0; pready = 1'b0; req = 4'b1010;
        wait_access("t5_access");
        chk("t5_gnt3", paddr_o, 32'h30);
        preset = 1'b1;
        #1;
        chk("t5_rst_psel", psel_o, 0);
        chk("t5_rst_penable", penable_o, 0);
        chk("t5_rst_paddr", paddr_o, 0);
        chk("t5_rst_rdata", rdata_o, 0);
        chk("t5_rst_done", done_o, 0);
        chk("t5_rst_err", err_o, 0);
        @(negedge pclk);
        preset = 1'b0; pready = 1'b1;
        q_grant.delete();
        wait_idle("t5_done", 30);
        chk("t5_count", q_grant.size(), 2);
        if (q_grant.size() == 2) begin
            chk("t5_first", q_grant[0], 1);
            chk("t5_second", q_grant[1], 3);
        end
        chk("t5_rdata", rdata_o, 32'h0BADCAFE);
`ifdef APB_TIMEOUT_EN
        // 6: slave never ready -> abort with error after TMO wait cycles
        begin
            int n = 0, waits = 0;
            @(negedge pclk);
            pready = 1'b0; wr[0] = 1'b0; prdata = 32'hCAFEF00D; req = 4'b0001;
            while (!done_o[0] && n < 60) begin
                @(negedge pclk);
                n++;
                if (penable_o) waits++;
            end
            chk("t6_done", done_o, 4'b0001);
            chk("t6_err", err_o, 1);
            chk("t6_rdata", rdata_o, 32'h0BADCAFE);
            chk("t6_waits", waits, TMO);
            chk("t6_psel", psel_o, 0);
            pready = 1'b1;
        end
`endif
        repeat (3) @(negedge pclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
